// File: rtl/fifo_burst_rd_pkg.sv
// fifo_burst_rd_pkg
//   Shared types and constants for the burst read controller.
//   - fifo_burst_rd_state_e : controller FSM states
//   - SKID_DEPTH            : entries in the output skid buffer
package fifo_burst_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } fifo_burst_rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_rd_skid_buf.sv
// skid_buf
//   Two-entry valid/ready buffer. in_ready_o is a decode of the registered
//   occupancy, so it never depends on out_ready_i in the same cycle.
//   Ports:
//     clk_i, rst_n_i   clock, asynchronous active-low reset
//     flush_i          synchronous clear of occupancy
//     in_valid_i/in_ready_o/in_data_i     upstream side
//     out_valid_o/out_ready_i/out_data_o  downstream side (data from a register)
module skid_buf
  import fifo_burst_rd_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_d0;   // head entry, drives the output
  logic [WIDTH-1:0] r_d1;   // second entry, only used while the head is stalled
  logic             w_push;
  logic             w_pop;

  assign in_ready_o  = (r_cnt != 2'(SKID_DEPTH));
  assign out_valid_o = (r_cnt != 2'd0);
  assign out_data_o  = r_d0;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else if (flush_i) begin
      r_cnt <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_d0  <= in_data_i;
            r_cnt <= 2'd1;
          end
        end
        2'd1: begin
          // Push and pop together: the new beat replaces the departing head.
          if (w_push && w_pop) begin
            r_d0 <= in_data_i;
          end else if (w_push) begin
            r_d1  <= in_data_i;
            r_cnt <= 2'd2;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_d0  <= r_d1;
            r_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd
//   Read-side controller for a synchronous fifo: waits until enough words are
//   present, pops a burst of burst_len_i+1 words and streams them out through
//   a 2-entry skid buffer with a last flag on the final beat.
//   Ports:
//     clk_i, rst_n_i                   clock, asynchronous active-low reset
//     flush_i                          abort burst, drop skid contents
//     en_i, burst_len_i                burst start enable, beats-1
//     fifo_empty_i/full_i/cnt_i/dat_i  fifo status and head data
//     fifo_pop_o                       pop strobe (independent of out_ready_i)
//     out_valid_o/ready_i/data_o/last_o  output stream
//     busy_o, burst_done_o             status, end-of-burst pulse
module fifo_burst_rd
  import fifo_burst_rd_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1,
  parameter int BURST_WIDTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        flush_i,
  input  logic                        en_i,
  input  logic [BURST_WIDTH-1:0]      burst_len_i,
  input  logic                        fifo_empty_i,
  input  logic                        fifo_full_i,
  input  logic [LOG_BUFFER_DEPTH-1:0] fifo_cnt_i,
  input  logic [DATA_WIDTH-1:0]       fifo_dat_i,
  output logic                        fifo_pop_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        burst_done_o
);

  localparam int OCC_W = LOG_BUFFER_DEPTH + 1;
  localparam int THR_W = (BURST_WIDTH + 1 > OCC_W) ? BURST_WIDTH + 1 : OCC_W;

  fifo_burst_rd_state_e   r_state;
  logic [BURST_WIDTH-1:0] r_beats_left;
  logic                   r_done;

  logic [OCC_W-1:0]       w_occ;
  logic [THR_W-1:0]       w_len_p1;
  logic [THR_W-1:0]       w_thr;
  logic                   w_start;
  logic                   w_pop;
  logic                   w_skid_rdy;
  logic                   w_skid_vld;
  logic [DATA_WIDTH:0]    w_skid_in;
  logic [DATA_WIDTH:0]    w_skid_out;
  logic                   w_hs_last;

  // The fifo count wraps to 0 when full, so full must override it.
  assign w_occ    = fifo_full_i ? OCC_W'(BUFFER_DEPTH) : {1'b0, fifo_cnt_i};
  // Bursts longer than the fifo can only wait for a full fifo.
  assign w_len_p1 = THR_W'(burst_len_i) + THR_W'(1);
  assign w_thr    = (w_len_p1 > THR_W'(BUFFER_DEPTH)) ? THR_W'(BUFFER_DEPTH) : w_len_p1;
  assign w_start  = (r_state == IDLE) & en_i & ~flush_i & (THR_W'(w_occ) >= w_thr);

  // Pop uses only the registered skid-ready flag, never out_ready_i.
  assign w_pop     = (r_state == BURST) & ~fifo_empty_i & w_skid_rdy & ~flush_i;
  assign w_skid_in = {(r_beats_left == '0), fifo_dat_i};
  assign w_hs_last = w_skid_vld & out_ready_i & w_skid_out[DATA_WIDTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_done       <= 1'b0;
    end else if (flush_i) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state      <= BURST;
            r_beats_left <= burst_len_i;
          end
        end
        BURST: begin
          if (w_pop) begin
            if (r_beats_left == '0) begin
              r_state <= DRAIN;
            end else begin
              r_beats_left <= r_beats_left - BURST_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (w_hs_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .in_valid_i (w_pop),
    .in_ready_o (w_skid_rdy),
    .in_data_i  (w_skid_in),
    .out_valid_o(w_skid_vld),
    .out_ready_i(out_ready_i),
    .out_data_o (w_skid_out)
  );

  assign fifo_pop_o   = w_pop;
  assign out_valid_o  = w_skid_vld;
  assign out_data_o   = w_skid_out[DATA_WIDTH-1:0];
  // Stale skid contents after a flush must not show a last flag.
  assign out_last_o   = w_skid_vld & w_skid_out[DATA_WIDTH];
  assign busy_o       = (r_state != IDLE);
  assign burst_done_o = r_done;

endmodule

// File: tb/tb_fifo_burst_rd.sv
// tb_fifo_burst_rd
//   Directed bench for fifo_burst_rd with a behavioural fifo in front of it.
//   Expected beats are queued by the stimulus; a negedge monitor pops and
//   compares each output handshake and counts burst_done_o pulses.
module tb_fifo_burst_rd;
  localparam int DW  = 32;
  localparam int BD  = 8;
  localparam int LBD = 3;
  localparam int BW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           en = 1'b0;
  logic [BW-1:0]  len = '0;
  logic           fifo_empty, fifo_full;
  logic [LBD-1:0] fifo_cnt;
  logic [DW-1:0]  fifo_dat;
  logic           pop, out_valid, out_last, busy, done;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  out_data;

  always #5 clk = ~clk;

  fifo_burst_rd #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(BD), .LOG_BUFFER_DEPTH(LBD), .BURST_WIDTH(BW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .en_i(en), .burst_len_i(len),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_cnt_i(fifo_cnt),
    .fifo_dat_i(fifo_dat), .fifo_pop_o(pop), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy), .burst_done_o(done)
  );

  // Behavioural fifo feeding the DUT
  logic [DW-1:0] mem [BD];
  int            rp = 0, wp = 0, cnt = 0, pop_total = 0;
  logic          tb_push = 1'b0, tb_clr = 1'b0;
  logic [DW-1:0] tb_push_dat = '0;
  logic          w_do_push, w_do_pop;

  assign w_do_pop   = pop && (cnt > 0);
  assign w_do_push  = tb_push && ((cnt < BD) || w_do_pop);
  assign fifo_empty = (cnt == 0);
  assign fifo_full  = (cnt == BD);
  assign fifo_cnt   = LBD'(cnt);
  assign fifo_dat   = mem[rp];

  always @(posedge clk) begin
    if (tb_clr) begin
      rp <= 0; wp <= 0; cnt <= 0;
    end else begin
      if (w_do_push) begin
        mem[wp] <= tb_push_dat;
        wp      <= (wp + 1) % BD;
      end
      if (w_do_pop) begin
        rp        <= (rp + 1) % BD;
        pop_total <= pop_total + 1;
      end
      cnt <= cnt + (w_do_push ? 1 : 0) - (w_do_pop ? 1 : 0);
    end
  end

  // Scoreboard
  logic [DW:0] expq [$];
  int n_cmp = 0, n_err = 0, done_cnt = 0;

  initial begin : monitor
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          n_cmp++;
          if (expq.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: actual last=%0d data=%h, required no beat", out_last, out_data);
          end else begin
            e = expq.pop_front();
            if ({out_last, out_data} !== e) begin
              n_err++;
              $display("FAIL beat: actual last=%0d data=%h, required last=%0d data=%h",
                       out_last, out_data, e[DW], e[DW-1:0]);
            end
          end
        end
        if (pop) begin
          n_cmp++;
          if (fifo_empty) begin
            n_err++;
            $display("FAIL pop_on_empty: actual pop=1, required pop=0");
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout, required $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    tb_push     = 1'b1;
    tb_push_dat = d;
    tick();
    tb_push     = 1'b0;
  endtask

  task automatic exp_beat(input logic [DW-1:0] d, input logic l);
    expq.push_back({l, d});
  endtask

  task automatic wait_done(input string nm, input int lim);
    int prev;
    prev = done_cnt;
    for (int i = 0; i < lim; i++) begin
      if (done_cnt > prev) break;
      tick();
    end
    tick();
    tick();
    chk(nm, done_cnt, prev + 1);
  endtask

  initial begin : stim
    int d0, p0, npop;
    #2;
    tick();
    tick();
    // Reset values
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_pop",   pop, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    rst_n = 1'b1;
    tick();

    // 1: four words present, len=3, full-rate burst
    for (int i = 0; i < 4; i++) begin
      push_word(32'hA000_0000 + i);
      exp_beat(32'hA000_0000 + i, i == 3);
    end
    chk("t1_idle_busy", busy, 0);
    len = 8'd3; en = 1'b1;
    tick();
    chk("t1_busy", busy, 1);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_pop", pop, 1);
      tick();
      chk("t1_valid", out_valid, 1);
    end
    chk("t1_pop_end", pop, 0);
    d0 = done_cnt;
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_done_cnt", done_cnt, d0 + 1);

    // 2: burst waits for occupancy to reach the threshold
    len = 8'd3; en = 1'b1;
    push_word(32'hB000_0000); exp_beat(32'hB000_0000, 1'b0);
    push_word(32'hB000_0001); exp_beat(32'hB000_0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_nopop", pop, 0);
      chk("t2_nobusy", busy, 0);
    end
    push_word(32'hB000_0002); exp_beat(32'hB000_0002, 1'b0);
    push_word(32'hB000_0003); exp_beat(32'hB000_0003, 1'b1);
    chk("t2_busy_at_occ4", busy, 0);
    tick();
    chk("t2_busy_start", busy, 1);
    en = 1'b0;
    wait_done("t2_done", 40);

    // 3: consumer stalled, skid fills after two pops
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hC000_0000 + i);
      exp_beat(32'hC000_0000 + i, i == 3);
    end
    len = 8'd3; en = 1'b1;
    tick();
    en = 1'b0;
    npop = 0;
    for (int k = 0; k < 6; k++) begin
      npop += int'(pop);
      tick();
    end
    chk("t3_pops", npop, 2);
    chk("t3_pop_stall", pop, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 32'hC000_0000);
      chk("t3_hold_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t3_done", 40);

    // 4: 16-beat burst from an 8-deep fifo refilled every other cycle
    for (int i = 0; i < 8; i++) push_word(32'hE000_0000 + i);
    for (int i = 0; i < 16; i++) exp_beat(32'hE000_0000 + i, i == 15);
    p0 = pop_total;
    len = 8'd15; en = 1'b1;
    tick();
    chk("t4_busy", busy, 1);
    en  = 1'b0;
    len = 8'd0;  // latched length must be kept
    fork
      begin
        for (int i = 8; i < 16; i++) begin
          push_word(32'hE000_0000 + i);
          tick();
        end
      end
      wait_done("t4_done", 200);
    join
    chk("t4_pops", pop_total - p0, 16);

    // 5: flush mid-burst with one beat held in the skid
    for (int i = 0; i < 6; i++) push_word(32'hF000_0000 + i);
    exp_beat(32'hF000_0000, 1'b0);
    exp_beat(32'hF000_0001, 1'b0);
    len = 8'd3; en = 1'b1;
    tick();
    en = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("t5_pop_flush", pop, 0);
    d0 = done_cnt;
    tick();
    flush = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pop", pop, 0);
    tick(); tick();
    chk("t5_no_done", done_cnt, d0);
    exp_beat(32'hF000_0003, 1'b0);
    exp_beat(32'hF000_0004, 1'b1);
    out_ready = 1'b1;
    len = 8'd1; en = 1'b1;
    tick();
    en = 1'b0;
    wait_done("t5_done", 40);
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;

    // 6a: asynchronous reset mid-burst
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h6000_0000 + i);
    len = 8'd3; en = 1'b1;
    tick();
    en = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data",  out_data, 0);
    chk("t6_rst_last",  out_last, 0);
    chk("t6_rst_pop",   pop, 0);
    chk("t6_rst_busy",  busy, 0);
    chk("t6_rst_done",  done, 0);
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // 6b: single-beat burst
    push_word(32'hC0DE_0001);
    exp_beat(32'hC0DE_0001, 1'b1);
    len = 8'd0; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("t6_single_valid", out_valid, 1);
    chk("t6_single_last", out_last, 1);
    chk("t6_single_data", out_data, 32'hC0DE_0001);
    tick();
    chk("t6_single_done", done, 1);
    tick();
    chk("t6_single_done_pulse", done, 0);

    tick(); tick(); tick();
    chk("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
